// File: rtl/writeback_register_file.sv
// Writeback stage plus 32-entry register file: selects the writeback value,
// commits it on the rising edge, and bypasses it to both read ports in the same cycle.
module writeback_register_file #(
  parameter int             N           = 32,
  parameter logic [N-1:0]   valor_reset = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] PCPlus4Input,
  input  logic [N-1:0] ReadDataInput,
  input  logic [N-1:0] ALUResultInput,
  input  logic [4:0]   WriteRegisterInput,
  input  logic [1:0]   MemtoRegInput,
  input  logic         RegWriteInput,
  input  logic [4:0]   ReadRegister1,
  input  logic [4:0]   ReadRegister2,
  output logic [N-1:0] ReadData1,
  output logic [N-1:0] ReadData2,
  output logic [N-1:0] WriteDataOutput,
  output logic [31:0]  WriteCount
);

  // Register 0 has no storage; it is hardwired to zero on both read ports.
  logic [N-1:0] r_regs [1:31];
  logic [31:0]  r_write_count;

  logic [N-1:0] w_write_data;
  logic         w_commit;
  logic [N-1:0] w_stored1;
  logic [N-1:0] w_stored2;

  always_comb begin
    w_write_data = ALUResultInput;
    case (MemtoRegInput)
      2'b01:   w_write_data = ReadDataInput;
      2'b10:   w_write_data = PCPlus4Input;
      default: w_write_data = ALUResultInput;
    endcase
  end

  // Holding reset low suppresses both the commit and the bypass path.
  assign w_commit = reset && RegWriteInput && (WriteRegisterInput != 5'd0);

  always_comb begin
    w_stored1 = '0;
    w_stored2 = '0;
    if (ReadRegister1 != 5'd0) w_stored1 = r_regs[ReadRegister1];
    if (ReadRegister2 != 5'd0) w_stored2 = r_regs[ReadRegister2];
  end

  always_comb begin
    ReadData1 = w_stored1;
    ReadData2 = w_stored2;
    if (w_commit && (WriteRegisterInput == ReadRegister1)) ReadData1 = w_write_data;
    if (w_commit && (WriteRegisterInput == ReadRegister2)) ReadData2 = w_write_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 1; i < 32; i++) r_regs[i] <= valor_reset;
      r_write_count <= '0;
    end else if (w_commit) begin
      r_regs[WriteRegisterInput] <= w_write_data;
      r_write_count              <= r_write_count + 32'd1;
    end
  end

  assign WriteDataOutput = w_write_data;
  assign WriteCount      = r_write_count;

endmodule

// File: tb/tb_writeback_register_file.sv
// Directed bench for writeback_register_file: a vector table for the steady-state
// behaviour plus hand-written reset sequences.
module tb_writeback_register_file;

  localparam logic [31:0] VR = 32'hC0DE_0001;

  logic        clk;
  logic        reset;
  logic [31:0] pc4, rdata, alu;
  logic [4:0]  wreg, rr1, rr2;
  logic [1:0]  m2r;
  logic        we;
  logic [31:0] rd1, rd2, wd, cnt;

  int tests;
  int fails;

  writeback_register_file #(.N(32), .valor_reset(VR)) dut (
    .clk                (clk),
    .reset              (reset),
    .PCPlus4Input       (pc4),
    .ReadDataInput      (rdata),
    .ALUResultInput     (alu),
    .WriteRegisterInput (wreg),
    .MemtoRegInput      (m2r),
    .RegWriteInput      (we),
    .ReadRegister1      (rr1),
    .ReadRegister2      (rr2),
    .ReadData1          (rd1),
    .ReadData2          (rd2),
    .WriteDataOutput    (wd),
    .WriteCount         (cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc4, rdata, alu;
    logic [4:0]  wreg;
    logic [1:0]  m2r;
    logic        we;
    logic [4:0]  rr1, rr2;
    logic [31:0] e_rd1, e_rd2, e_wd, e_cnt;
  } vec_t;

  vec_t vecs[14];

  function automatic vec_t mk(logic [31:0] p, logic [31:0] r, logic [31:0] a,
                              logic [4:0] w, logic [1:0] m, logic e,
                              logic [4:0] s1, logic [4:0] s2,
                              logic [31:0] x1, logic [31:0] x2,
                              logic [31:0] xw, logic [31:0] xc);
    vec_t v;
    v.pc4 = p; v.rdata = r; v.alu = a; v.wreg = w; v.m2r = m; v.we = e;
    v.rr1 = s1; v.rr2 = s2; v.e_rd1 = x1; v.e_rd2 = x2; v.e_wd = xw; v.e_cnt = xc;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] p, input logic [31:0] r, input logic [31:0] a,
                       input logic [4:0] w, input logic [1:0] m, input logic e,
                       input logic [4:0] s1, input logic [4:0] s2);
    pc4 = p; rdata = r; alu = a; wreg = w; m2r = m; we = e; rr1 = s1; rr2 = s2;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    drive(32'h0, 32'h0, 32'h0, 5'd0, 2'b00, 1'b0, 5'd0, 5'd0);
    reset = 1'b1;
    #1 reset = 1'b0;

    // Reads during reset: stored reset value, bypass disabled even with a write pending.
    #1 drive(32'h0, 32'h0, 32'hFFFF_0000, 5'd6, 2'b00, 1'b1, 5'd6, 5'd0);
    #1;
    check("in_reset_rd1_r6_no_bypass", rd1, VR);
    check("in_reset_rd2_r0", rd2, 32'h0);
    @(posedge clk);
    #1 check("in_reset_cnt_after_edge", cnt, 32'h0);
    check("in_reset_r6_not_written", rd1, VR);

    // Release at a negedge, then sweep all 32 indices on both ports.
    @(negedge clk);
    we = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 32; i++) begin
      rr1 = 5'(i);
      rr2 = 5'(31 - i);
      #1;
      check($sformatf("reset_sweep_rd1_r%0d", i), rd1, (i == 0) ? 32'h0 : VR);
      check($sformatf("reset_sweep_rd2_r%0d", 31 - i), rd2, (i == 31) ? 32'h0 : VR);
    end
    check("reset_cnt", cnt, 32'h0);

    // Each row: outputs checked before its rising edge; e_cnt is the count before that edge.
    vecs[0]  = mk(32'h0, 32'h0, 32'h0, 5'd0, 2'b00, 1'b0, 5'd5, 5'd0, VR, 32'h0, 32'h0, 32'd0);
    vecs[1]  = mk(32'h0, 32'h0, 32'hDEADBEEF, 5'd5, 2'b00, 1'b1, 5'd1, 5'd2, VR, VR, 32'hDEADBEEF, 32'd0);
    vecs[2]  = mk(32'h0, 32'h0, 32'h12345678, 5'd5, 2'b00, 1'b0, 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 32'h12345678, 32'd1);
    vecs[3]  = mk(32'h22, 32'h11, 32'h33, 5'd1, 2'b01, 1'b1, 5'd5, 5'd1, 32'hDEADBEEF, 32'h11, 32'h11, 32'd1);
    vecs[4]  = mk(32'h22, 32'h11, 32'h33, 5'd2, 2'b10, 1'b1, 5'd1, 5'd2, 32'h11, 32'h22, 32'h22, 32'd2);
    vecs[5]  = mk(32'h22, 32'h11, 32'h33, 5'd3, 2'b11, 1'b1, 5'd2, 5'd3, 32'h22, 32'h33, 32'h33, 32'd3);
    vecs[6]  = mk(32'h0, 32'h0, 32'h0, 5'd0, 2'b00, 1'b0, 5'd1, 5'd3, 32'h11, 32'h33, 32'h0, 32'd4);
    vecs[7]  = mk(32'h0, 32'h0, 32'hFFFFFFFF, 5'd0, 2'b00, 1'b1, 5'd0, 5'd0, 32'h0, 32'h0, 32'hFFFFFFFF, 32'd4);
    vecs[8]  = mk(32'h0, 32'h0, 32'h0, 5'd0, 2'b00, 1'b0, 5'd0, 5'd2, 32'h0, 32'h22, 32'h0, 32'd4);
    vecs[9]  = mk(32'h0, 32'h0, 32'hA5A5A5A5, 5'd7, 2'b00, 1'b1, 5'd7, 5'd7, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'd4);
    vecs[10] = mk(32'h0, 32'h0, 32'h00005555, 5'd7, 2'b00, 1'b0, 5'd7, 5'd7, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h00005555, 32'd5);
    vecs[11] = mk(32'h0, 32'h0, 32'h0, 5'd0, 2'b00, 1'b0, 5'd7, 5'd31, 32'hA5A5A5A5, VR, 32'h0, 32'd5);
    vecs[12] = mk(32'h0, 32'h77, 32'h0, 5'd31, 2'b01, 1'b1, 5'd31, 5'd30, 32'h77, VR, 32'h77, 32'd5);
    vecs[13] = mk(32'h0, 32'h0, 32'h0, 5'd0, 2'b00, 1'b0, 5'd31, 5'd30, 32'h77, VR, 32'h0, 32'd6);

    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      drive(vecs[k].pc4, vecs[k].rdata, vecs[k].alu, vecs[k].wreg, vecs[k].m2r,
            vecs[k].we, vecs[k].rr1, vecs[k].rr2);
      #1;
      check($sformatf("vec%0d_rd1", k), rd1, vecs[k].e_rd1);
      check($sformatf("vec%0d_rd2", k), rd2, vecs[k].e_rd2);
      check($sformatf("vec%0d_wd", k), wd, vecs[k].e_wd);
      check($sformatf("vec%0d_cnt", k), cnt, vecs[k].e_cnt);
    end

    // Reset asserted mid-cycle with a write to r9 pending.
    @(negedge clk);
    drive(32'h0, 32'h0, 32'h99, 5'd9, 2'b00, 1'b1, 5'd9, 5'd7);
    #1 check("pre_reset_r9_bypass", rd1, 32'h99);
    check("pre_reset_cnt", cnt, 32'd6);
    #1 reset = 1'b0;
    #1;
    check("mid_reset_r9", rd1, VR);
    check("mid_reset_r7", rd2, VR);
    check("mid_reset_cnt", cnt, 32'd0);
    @(posedge clk);
    @(negedge clk);
    we = 1'b0;
    reset = 1'b1;
    #1;
    check("post_release_r9", rd1, VR);
    check("post_release_cnt", cnt, 32'd0);

    // First write after release commits on the very next edge.
    @(negedge clk);
    reset = 1'b0;
    #1;
    drive(32'h0, 32'h0, 32'h4444, 5'd4, 2'b00, 1'b1, 5'd4, 5'd4);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    we = 1'b0;
    #1;
    check("first_write_r4", rd1, 32'h4444);
    check("first_write_cnt", cnt, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
